// File: rtl/board_io_ctrl_if.sv
// board_io_ctrl_if: pin/core bundle of the board I/O controller.
// slave  (controller): in locked, btn_raw, data; out reset_out, btn_level, btn_press, led.
// master (pins/core):  the opposite directions.
interface board_io_ctrl_if #(
  parameter int NUM_BTN = 4,
  parameter int NUM_CH  = 6,
  parameter int CH_W    = 16,
  parameter int LED_W   = 8
);
  logic                   locked;
  logic [NUM_BTN-1:0]     btn_raw;
  logic [NUM_CH*CH_W-1:0] data;
  logic                   reset_out;
  logic [NUM_BTN-1:0]     btn_level;
  logic [NUM_BTN-1:0]     btn_press;
  logic [LED_W-1:0]       led;
  modport master (output locked, btn_raw, data, input reset_out, btn_level, btn_press, led);
  modport slave  (input locked, btn_raw, data, output reset_out, btn_level, btn_press, led);
endinterface

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: PLL-lock reset sequencer, button debounce and LED channel status display.
// clk/rst_n: clock and async active-low reset.
// io.locked/btn_raw: async pins, double-synchronized; io.data: channel 0 in the MSBs.
// io.reset_out: core reset; io.btn_level/btn_press: debounced level and rise pulse; io.led: status.
module board_io_ctrl #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LOCK_HOLD       = 1024,
  parameter int NUM_CH          = 6,
  parameter int CH_W            = 16,
  parameter int LED_W           = 8,
  parameter int MODE_BTN        = 0,
  parameter int FLASH_CYCLES    = 4096
) (
  input logic clk,
  input logic rst_n,
  board_io_ctrl_if.slave io
);
  localparam int LW = $clog2(LOCK_HOLD) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int FW = $clog2(FLASH_CYCLES) + 1;
  localparam int SW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic {HOLD, RUN} state_t;
  state_t             state;
  logic [LW-1:0]      lcnt;
  logic [1:0]         lock_q;
  logic [NUM_BTN-1:0] btn_q0, btn_q1, prev;
  logic [DW-1:0]      dcnt [NUM_BTN];
  logic [SW-1:0]      sel;
  logic [FW-1:0]      flash;
  logic [LED_W-1:0]   top;
  logic               lock_s;
  assign lock_s = lock_q[1];
  // top LED_W bits of channel sel
  assign top = LED_W'(io.data >> (CH_W * (NUM_CH - 1 - int'(sel)) + CH_W - LED_W));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lock_q <= '0;
      btn_q0 <= '0;
      btn_q1 <= '0;
    end else begin
      lock_q <= {lock_q[0], io.locked};
      btn_q0 <= io.btn_raw;
      btn_q1 <= btn_q0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= HOLD;
      lcnt         <= '0;
      io.reset_out <= 1'b1;
    end else if (!lock_s) begin
      state        <= HOLD;
      lcnt         <= '0;
      io.reset_out <= 1'b1;
    end else if (state == HOLD) begin
      if (lcnt == LW'(LOCK_HOLD - 1)) begin
        state        <= RUN;
        lcnt         <= '0;
        io.reset_out <= 1'b0;
      end else lcnt <= lcnt + LW'(1);
    end
  // everything downstream is held cleared while the core is in reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || io.reset_out) begin
      io.btn_level <= '0;
      io.btn_press <= '0;
      io.led       <= '0;
      prev         <= '0;
      sel          <= '0;
      flash        <= '0;
      for (int i = 0; i < NUM_BTN; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++)
        if (btn_q1[i] == io.btn_level[i]) dcnt[i] <= '0;
        else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          io.btn_level[i] <= btn_q1[i];
          dcnt[i]         <= '0;
        end else dcnt[i] <= dcnt[i] + DW'(1);
      prev         <= io.btn_level;
      io.btn_press <= io.btn_level & ~prev;
      if (io.btn_press[MODE_BTN]) begin
        sel   <= sel == SW'(NUM_CH - 1) ? '0 : sel + SW'(1);
        flash <= FW'(FLASH_CYCLES);
      end else if (flash != '0) flash <= flash - FW'(1);
      io.led <= flash != '0 ? LED_W'(1) << sel : top;
    end
endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: directed scoreboard bench for board_io_ctrl.
module tb_board_io_ctrl;
  localparam logic [95:0] D0 = {16'hA511, 16'h3C22, 16'h7733, 16'h8844, 16'h9955, 16'hEE66};
  localparam logic [95:0] D1 = {16'hA511, 16'h5A22, 16'h7733, 16'h8844, 16'h9955, 16'hEE66};
  localparam int RO = 0, LV = 1, PR = 2, LD = 3;
  typedef struct {int cyc; int sig; logic [31:0] val; string name;} exp_t;
  exp_t q[$];
  logic clk = 1'b0, rst_n;
  int cyc = 0, n_run = 0, n_fail = 0;
  board_io_ctrl_if #(.NUM_BTN(4), .NUM_CH(6), .CH_W(16), .LED_W(8)) io();
  board_io_ctrl #(.DEBOUNCE_CYCLES(4), .LOCK_HOLD(8), .FLASH_CYCLES(5)) dut (
    .clk(clk), .rst_n(rst_n), .io(io)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] get(int s);
    return s == RO ? 32'(io.reset_out) : s == LV ? 32'(io.btn_level) :
           s == PR ? 32'(io.btn_press) : 32'(io.led);
  endfunction
  always @(negedge clk)
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].cyc == cyc) begin
        n_run++;
        if (get(q[i].sig) !== q[i].val) begin
          n_fail++;
          $display("FAIL %s @%0d: got %h want %h", q[i].name, cyc, get(q[i].sig), q[i].val);
        end
        q.delete(i);
      end
  task automatic exp(int d, int s, logic [31:0] v, string n);
    q.push_back('{cyc + d, s, v, n});
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic mode_press(logic [3:0] mask, int s, logic [7:0] t);
    io.btn_raw = mask;
    exp(6, PR, 0, "press_early");
    exp(7, PR, 32'(mask), "press_pulse");
    exp(8, PR, 0, "press_end");
    exp(9, LD, 32'(8'd1 << s), "flash_first");
    exp(13, LD, 32'(8'd1 << s), "flash_last");
    exp(14, LD, 32'(t), "chan_after_flash");
    tick(8);
    io.btn_raw = 4'h0;
    tick(8);
  endtask
  initial begin
    rst_n = 1'b0; io.locked = 1'b1; io.btn_raw = 4'hF; io.data = D0;
    tick(3);
    exp(0, RO, 1, "rst_reset_out"); exp(0, LV, 0, "rst_level");
    exp(0, PR, 0, "rst_press"); exp(0, LD, 0, "rst_led");
    tick(1);
    rst_n = 1'b1; io.btn_raw = 4'h0;
    exp(9, RO, 1, "seq_hold"); exp(10, RO, 0, "seq_release"); exp(15, RO, 0, "seq_stays");
    tick(16);
    io.locked = 1'b0;
    exp(2, RO, 0, "drop_before"); exp(3, RO, 1, "drop_reset");
    tick(4);
    io.locked = 1'b1;
    exp(8, RO, 1, "glitch_hold"); exp(16, RO, 1, "glitch_count"); exp(17, RO, 0, "glitch_release");
    tick(5); io.locked = 1'b0; tick(2); io.locked = 1'b1; tick(12);
    io.btn_raw[2] = 1'b1;
    exp(9, LV, 0, "deb_not_yet"); exp(10, LV, 4'b0100, "deb_rise");
    exp(10, PR, 0, "deb_press_pre"); exp(11, PR, 4'b0100, "deb_press");
    exp(12, PR, 0, "deb_press_single");
    tick(1); io.btn_raw[2] = 1'b0; tick(1); io.btn_raw[2] = 1'b1;
    tick(1); io.btn_raw[2] = 1'b0; tick(1); io.btn_raw[2] = 1'b1;
    tick(10);
    io.btn_raw[2] = 1'b0;
    exp(5, LV, 4'b0100, "rel_not_yet"); exp(6, LV, 0, "rel_fall");
    exp(6, PR, 0, "rel_no_press"); exp(7, PR, 0, "rel_no_press2");
    tick(10);
    exp(0, LD, 8'hA5, "led_ch0");
    tick(2);
    mode_press(4'b0001, 1, 8'h3C);
    io.data = D1;
    exp(0, LD, 8'h3C, "data_old"); exp(1, LD, 8'h5A, "data_follow");
    tick(2);
    mode_press(4'b0001, 2, 8'h77);
    mode_press(4'b0001, 3, 8'h88);
    mode_press(4'b0001, 4, 8'h99);
    mode_press(4'b0001, 5, 8'hEE);
    mode_press(4'b0001, 0, 8'hA5);
    mode_press(4'b1001, 1, 8'h5A);
    io.btn_raw = 4'b0010;
    exp(7, LV, 4'b0010, "b1_level"); exp(7, PR, 4'b0010, "b1_press_no_sel");
    exp(9, LD, 8'h5A, "b1_keeps_sel");
    tick(10);
    io.locked = 1'b0;
    exp(3, LV, 4'b0010, "loss_level_held"); exp(3, RO, 1, "loss_reset");
    exp(4, LV, 0, "loss_level_clr"); exp(4, LD, 0, "loss_led_clr");
    tick(6);
    io.btn_raw = 4'h0; io.locked = 1'b1;
    exp(9, RO, 1, "relock_hold"); exp(10, RO, 0, "relock_release");
    exp(10, LD, 0, "relock_led_idle"); exp(11, LD, 8'hA5, "relock_sel_cleared");
    tick(14);
    rst_n = 1'b0;
    exp(0, RO, 1, "async_reset_out"); exp(0, LD, 0, "async_led");
    #1;
    n_run++;
    if (io.reset_out !== 1'b1) begin n_fail++; $display("FAIL now_reset_out: got %b", io.reset_out); end
    n_run++;
    if (io.led !== 8'h00) begin n_fail++; $display("FAIL now_led: got %h", io.led); end
    n_run++;
    if (io.btn_level !== 4'h0) begin n_fail++; $display("FAIL now_level: got %h", io.btn_level); end
    n_run++;
    if (io.btn_press !== 4'h0) begin n_fail++; $display("FAIL now_press: got %h", io.btn_press); end
    tick(3);
    foreach (q[i]) begin
      n_run++; n_fail++;
      $display("FAIL %s: never checked, want %h at %0d", q[i].name, q[i].val, q[i].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
